// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported unified memory between the CPU instruction-fetch
//   port and its load/store port. Round-robin arbitration between the two
//   ports, fixed-latency memory sequencing, one outstanding transaction.
//
//   Sequence per transaction: IDLE -> ACCESS -> WAIT (LATENCY cycles) -> RESP.
//   Every output is a register, so a request sampled in IDLE at cycle T shows
//   its grant at T+1 and its response at T+2+LATENCY.
//
// Ports
//   clk, rst                  clock (rising edge), async reset (active high)
//   i_req/i_addr              ifetch request; held until i_gnt
//   i_gnt/i_rvalid/i_rdata    ifetch grant pulse, response pulse, fetched word
//   d_req/d_we/d_addr/d_wdata data request; held until d_gnt
//   d_gnt/d_rvalid/d_rdata    data grant pulse, response pulse, load data
//                             (0 for stores)
//   mem_en/mem_we             memory strobe and write enable (one ACCESS cycle)
//   mem_addr/mem_wdata        memory address/write data, held until next ACCESS
//   mem_rdata                 memory read data, valid LATENCY cycles after mem_en

module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    // Wide enough to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sel_d;    // current transaction belongs to the data port
    logic          lat_we;   // current transaction is a store
    logic          last_d;   // last grant went to the data port
    logic          pick_d;

    // A lone requester wins; with both pending, the port not granted last wins.
    assign pick_d = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
            last_d    <= 1'b1;   // ifetch wins the first contended grant
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register in
            // this block updates from the values present before the edge.
            // Pulse outputs default low; only the transitions below raise them.
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;

            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        sel_d     <= pick_d;
                        last_d    <= pick_d;
                        lat_we    <= pick_d && d_we;
                        i_gnt     <= !pick_d;
                        d_gnt     <= pick_d;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_d && d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_wdata <= pick_d ? d_wdata : '0;
                        cnt       <= CW'(LATENCY - 1);
                        state     <= ACCESS;
                    end
                end

                ACCESS: state <= WAIT;

                // The final WAIT cycle (cnt == 0) is the one where mem_rdata
                // is valid; it is captured straight into the response regs.
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RESP;
                        if (sel_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= lat_we ? '0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end
                end

                // Requests are not sampled here; they wait for IDLE.
                RESP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
